// File: rtl/pipe_pkg.sv
// Shared constants for the elastic inter-stage pipeline registers.
// Per-boundary field widths and EX/MEM payload packing.
package pipe_pkg;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 9;
    localparam int ID_EX_DATA_W  = 101;
    localparam int EX_MEM_CTRL_W = 4;
    localparam int EX_MEM_DATA_W = 69;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 69;

    localparam int ALU_OUT_LSB = 0;
    localparam int ALU_OUT_W   = 32;
    localparam int STORE_LSB   = 32;
    localparam int STORE_W     = 32;
    localparam int RD_LSB      = 64;
    localparam int RD_W        = 5;

    typedef struct packed {
        logic [RD_W-1:0]      rd;
        logic [STORE_W-1:0]   store_data;
        logic [ALU_OUT_W-1:0] alu_out;
    } ex_mem_data_t;

    function automatic logic [EX_MEM_DATA_W-1:0] pack_ex_mem(
        input logic [ALU_OUT_W-1:0] alu_out,
        input logic [STORE_W-1:0]   store_data,
        input logic [RD_W-1:0]      rd
    );
        ex_mem_data_t p;
        p.alu_out    = alu_out;
        p.store_data = store_data;
        p.rd         = rd;
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline register: valid, control and payload.
// Control is forced to zero whenever the stage holds a bubble.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= '0;
            data_o  <= '0;
        end else if (flush_i) begin
            // payload is left in place; only valid and control are killed
            valid_o <= 1'b0;
            ctrl_o  <= '0;
        end else if (load_i) begin
            valid_o <= valid_i;
            ctrl_o  <= valid_i ? ctrl_i : '0;
            data_o  <= data_i;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH elastic pipeline stages with valid/ready backpressure,
// bubble collapsing, flush and a registered occupancy count.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int DEPTH  = 1,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [OCC_W-1:0]  occ_o
);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  r;
    logic [CTRL_W-1:0] c [DEPTH];
    logic [DATA_W-1:0] d [DEPTH];
    logic [OCC_W-1:0]  occ_q;
    logic              in_xfer;
    logic              out_xfer;

    // A stage accepts if it or any stage ahead of it is empty,
    // or the head is draining; flattened to avoid a comb self-loop.
    always_comb begin
        logic acc;
        acc = out_ready_i;
        r   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc  = acc | ~v[k];
            r[k] = acc;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              src_v;
        logic [CTRL_W-1:0] src_c;
        logic [DATA_W-1:0] src_d;

        if (k == 0) begin : g_src
            assign src_v = in_valid_i;
            assign src_c = in_ctrl_i;
            assign src_d = in_data_i;
        end else begin : g_src
            assign src_v = v[k-1];
            assign src_c = c[k-1];
            assign src_d = d[k-1];
        end

        pipe_stage #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .load_i  (r[k]),
            .valid_i (src_v),
            .ctrl_i  (src_c),
            .data_i  (src_d),
            .valid_o (v[k]),
            .ctrl_o  (c[k]),
            .data_o  (d[k])
        );
    end

    assign in_ready_o  = r[0];
    assign out_valid_o = v[DEPTH-1];
    assign out_ctrl_o  = c[DEPTH-1];
    assign out_data_o  = d[DEPTH-1];

    assign in_xfer  = in_valid_i & r[0];
    assign out_xfer = v[DEPTH-1] & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign occ_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain at DEPTH=3 (a_*) and DEPTH=2 (b_*).
// Accepted inputs are queued; every output transfer pops and compares.
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    typedef struct packed {
        logic [3:0]  c;
        logic [68:0] d;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [3:0]  a_in_ctrl, a_out_ctrl;
    logic [68:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [3:0]  b_in_ctrl, b_out_ctrl;
    logic [68:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    int          n_checks = 0;
    int          n_fail = 0;
    item_t       sb[$];

    logic        s_in_ready, s_out_valid, s_in_xfer, s_out_xfer;
    logic [3:0]  s_out_ctrl;
    logic [68:0] s_out_data;
    int          s_occ;

    always #5 clk = ~clk;

    pipe_stage_chain #(.CTRL_W(4), .DATA_W(69), .DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_ctrl_i(a_in_ctrl), .in_data_i(a_in_data),
        .flush_i(a_flush),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_ctrl_o(a_out_ctrl), .out_data_o(a_out_data),
        .occ_o(a_occ)
    );

    pipe_stage_chain #(.CTRL_W(4), .DATA_W(69), .DEPTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_ctrl_i(b_in_ctrl), .in_data_i(b_in_data),
        .flush_i(b_flush),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_ctrl_o(b_out_ctrl), .out_data_o(b_out_data),
        .occ_o(b_occ)
    );

    // Drive one cycle on the selected DUT, capture its outputs, clock.
    task automatic step(input bit sel, input logic iv, input logic [3:0] ic,
                        input logic [68:0] id, input logic ordy,
                        input logic fl);
        if (!sel) begin
            a_in_valid = iv; a_in_ctrl = ic; a_in_data = id;
            a_out_ready = ordy; a_flush = fl;
            b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        end else begin
            b_in_valid = iv; b_in_ctrl = ic; b_in_data = id;
            b_out_ready = ordy; b_flush = fl;
            a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        end
        #1;
        s_in_ready  = sel ? b_in_ready  : a_in_ready;
        s_out_valid = sel ? b_out_valid : a_out_valid;
        s_out_ctrl  = sel ? b_out_ctrl  : a_out_ctrl;
        s_out_data  = sel ? b_out_data  : a_out_data;
        s_occ       = sel ? int'(b_occ) : int'(a_occ);
        s_in_xfer   = iv && s_in_ready && !fl && !rst;
        s_out_xfer  = s_out_valid && ordy && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_ctrl = 4'hF; a_in_data = 69'h55;
        b_in_valid = 1'b1; b_in_ctrl = 4'hF; b_in_data = 69'h66;
        a_flush = 1'b0; b_flush = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 8;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid: got %b, required 0", a_out_valid); end
        if (a_out_ctrl !== 4'h0) begin n_fail++; $display("FAIL rst_a_ctrl: got %h, required 0", a_out_ctrl); end
        if (a_out_data !== 69'h0) begin n_fail++; $display("FAIL rst_a_data: got %h, required 0", a_out_data); end
        if (a_occ !== 2'd0) begin n_fail++; $display("FAIL rst_a_occ: got %0d, required 0", a_occ); end
        if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %b, required 0", b_out_valid); end
        if (b_out_ctrl !== 4'h0) begin n_fail++; $display("FAIL rst_b_ctrl: got %h, required 0", b_out_ctrl); end
        if (b_out_data !== 69'h0) begin n_fail++; $display("FAIL rst_b_data: got %h, required 0", b_out_data); end
        if (b_occ !== 2'd0) begin n_fail++; $display("FAIL rst_b_occ: got %0d, required 0", b_occ); end
        rst = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks += 2;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready: got %b, required 1", a_in_ready); end
        if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready: got %b, required 1", b_in_ready); end
    endtask

    task automatic test_stream();
        int          first = -1;
        int          last = -1;
        int          delivered = 0;
        int          occ_max = 0;
        logic        iv;
        logic [3:0]  ic;
        logic [68:0] id;
        item_t       exp;
        sb.delete();
        for (int cyc = 0; cyc < 16; cyc++) begin
            iv = (cyc < 8);
            ic = 4'(cyc + 1);
            id = 69'(cyc + 1);
            step(1'b0, iv, ic, id, 1'b1, 1'b0);
            n_checks++;
            if (s_occ !== sb.size()) begin
                n_fail++;
                $display("FAIL stream_occ: got %0d, required %0d", s_occ, sb.size());
            end
            if (s_occ > occ_max) occ_max = s_occ;
            if (s_out_xfer) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got %h, required none", s_out_data);
                end else begin
                    exp = sb.pop_front();
                    if ({s_out_ctrl, s_out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL stream_item: got %h/%h, required %h/%h",
                                 s_out_ctrl, s_out_data, exp.c, exp.d);
                    end
                    delivered++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
            if (s_in_xfer) sb.push_back(item_t'({ic, id}));
        end
        n_checks += 4;
        if (first !== 3) begin n_fail++; $display("FAIL stream_latency: got %0d, required 3", first); end
        if (last !== 10) begin n_fail++; $display("FAIL stream_last: got %0d, required 10", last); end
        if (delivered !== 8) begin n_fail++; $display("FAIL stream_count: got %0d, required 8", delivered); end
        if (occ_max !== 3) begin n_fail++; $display("FAIL stream_occmax: got %0d, required 3", occ_max); end
    endtask

    task automatic test_stall();
        int          delivered = 0;
        logic        iv;
        logic        ordy;
        logic [3:0]  ic;
        logic [68:0] id;
        item_t       exp;
        sb.delete();
        for (int cyc = 0; cyc < 14; cyc++) begin
            iv = 1'b0; ordy = 1'b1; ic = 4'h0; id = 69'h0;
            case (cyc)
                0: begin iv = 1'b1; ic = 4'h3; id = 69'hA; end
                2: begin iv = 1'b1; ic = 4'h5; id = 69'hB; end
                3: begin iv = 1'b1; ic = 4'h9; id = 69'hC; ordy = 1'b0; end
                4, 5: ordy = 1'b0;
                default: ;
            endcase
            step(1'b0, iv, ic, id, ordy, 1'b0);
            if (cyc == 3) begin
                n_checks += 2;
                if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_collapse_ready: got %b, required 1", s_in_ready); end
                if (s_out_valid !== 1'b1 || s_out_data !== 69'hA) begin
                    n_fail++;
                    $display("FAIL stall_head: got %b/%h, required 1/a", s_out_valid, s_out_data);
                end
            end
            if (cyc == 4) begin
                n_checks += 2;
                if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b, required 0", s_in_ready); end
                if (s_occ !== 3) begin n_fail++; $display("FAIL stall_occ: got %0d, required 3", s_occ); end
            end
            if (cyc == 5) begin
                n_checks++;
                if (s_out_valid !== 1'b1 || s_out_data !== 69'hA) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %b/%h, required 1/a", s_out_valid, s_out_data);
                end
            end
            if (s_out_xfer) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_extra: got %h, required none", s_out_data);
                end else begin
                    exp = sb.pop_front();
                    if ({s_out_ctrl, s_out_data} !== exp) begin
                        n_fail++;
                        $display("FAIL stall_item: got %h/%h, required %h/%h",
                                 s_out_ctrl, s_out_data, exp.c, exp.d);
                    end
                    delivered++;
                end
            end
            if (s_in_xfer) sb.push_back(item_t'({ic, id}));
        end
        n_checks += 2;
        if (delivered !== 3) begin n_fail++; $display("FAIL stall_count: got %0d, required 3", delivered); end
        if (sb.size() !== 0) begin n_fail++; $display("FAIL stall_lost: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_flush();
        logic [3:0]  ic;
        logic [68:0] id;
        logic [68:0] e1;
        item_t       exp;
        sb.delete();
        e1 = pack_ex_mem(32'd1, 32'h100, 5'd0);
        for (int k = 0; k < 3; k++) begin
            ic = 4'(k + 1);
            id = pack_ex_mem(32'(k + 1), 32'h100, 5'(k));
            step(1'b0, 1'b1, ic, id, 1'b0, 1'b0);
            if (s_in_xfer) sb.push_back(item_t'({ic, id}));
        end
        step(1'b0, 1'b1, 4'hF, 69'hDD, 1'b1, 1'b1);
        n_checks += 2;
        if (s_occ !== 3) begin n_fail++; $display("FAIL flush_full: got %0d, required 3", s_occ); end
        if (!s_out_xfer || sb.size() == 0) begin
            n_fail++;
            $display("FAIL flush_deliver: got xfer=%b, required 1", s_out_xfer);
        end else begin
            exp = sb.pop_front();
            if ({s_out_ctrl, s_out_data} !== exp) begin
                n_fail++;
                $display("FAIL flush_deliver: got %h/%h, required %h/%h",
                         s_out_ctrl, s_out_data, exp.c, exp.d);
            end
        end
        sb.delete();
        n_checks += 4;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", a_out_valid); end
        if (a_out_ctrl !== 4'h0) begin n_fail++; $display("FAIL flush_ctrl: got %h, required 0", a_out_ctrl); end
        if (a_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d, required 0", a_occ); end
        if (a_out_data !== e1) begin n_fail++; $display("FAIL flush_data_held: got %h, required %h", a_out_data, e1); end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b0);
            n_checks++;
            if (s_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak: got %h, required none", s_out_data);
            end
        end
    endtask

    task automatic test_bubble();
        for (int cyc = 0; cyc < 4; cyc++) begin
            step(1'b1, 1'b0, 4'hF, 69'h1234, 1'b1, 1'b0);
            n_checks += 2;
            if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b, required 0", s_out_valid); end
            if (s_out_ctrl !== 4'h0) begin n_fail++; $display("FAIL bubble_ctrl: got %h, required 0", s_out_ctrl); end
            if (cyc >= 2) begin
                n_checks++;
                if (s_out_data !== 69'h1234) begin
                    n_fail++;
                    $display("FAIL bubble_data: got %h, required 1234", s_out_data);
                end
            end
        end
    endtask

    task automatic test_midreset();
        int seen = 0;
        int when = -1;
        step(1'b1, 1'b1, 4'h6, 69'h51, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h7, 69'h52, 1'b0, 1'b0);
        n_checks++;
        if (b_occ !== 2'd2) begin n_fail++; $display("FAIL midrst_fill: got %0d, required 2", b_occ); end
        rst = 1'b1;
        step(1'b1, 1'b0, 4'h0, 69'h0, 1'b0, 1'b0);
        rst = 1'b0;
        n_checks += 4;
        if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", b_out_valid); end
        if (b_out_ctrl !== 4'h0) begin n_fail++; $display("FAIL midrst_ctrl: got %h, required 0", b_out_ctrl); end
        if (b_out_data !== 69'h0) begin n_fail++; $display("FAIL midrst_data: got %h, required 0", b_out_data); end
        if (b_occ !== 2'd0) begin n_fail++; $display("FAIL midrst_occ: got %0d, required 0", b_occ); end
        step(1'b1, 1'b1, 4'hA, 69'h77, 1'b1, 1'b0);
        n_checks++;
        if (s_in_xfer !== 1'b1) begin n_fail++; $display("FAIL midrst_accept: got %b, required 1", s_in_xfer); end
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 4'h0, 69'h0, 1'b1, 1'b0);
            if (s_out_valid) begin
                seen++;
                if (when < 0) when = k;
                n_checks++;
                if (s_out_ctrl !== 4'hA || s_out_data !== 69'h77) begin
                    n_fail++;
                    $display("FAIL midrst_item: got %h/%h, required a/77", s_out_ctrl, s_out_data);
                end
            end
        end
        n_checks += 2;
        if (when !== 2) begin n_fail++; $display("FAIL midrst_latency: got %0d, required 2", when); end
        if (seen !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d, required 1", seen); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
